// File: rtl/alt_detect_event_counter.sv
// Windowed event counter for the alternating-bit detector's z output.
// Counts samples of z per programmable window; reports totals, threshold hit and sticky overflow.
module alt_detect_event_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_in,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] threshold,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] last_count,
    output logic             hit,
    output logic             window_done,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_last_count;
    logic [WIN_W-1:0] r_win_cnt;
    logic             r_hit;
    logic             r_window_done;
    logic             r_overflow;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_last_nxt;
    logic [WIN_W-1:0] w_win_nxt;
    logic             w_hit_nxt;
    logic             w_done_nxt;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_sum;
    logic             w_win_last;

    // State and all output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_last_count  <= '0;
            r_win_cnt     <= '0;
            r_hit         <= 1'b0;
            r_window_done <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_last_count  <= w_last_nxt;
            r_win_cnt     <= w_win_nxt;
            r_hit         <= w_hit_nxt;
            r_window_done <= w_done_nxt;
            r_overflow    <= w_ovf_nxt;
            r_busy        <= (w_state_nxt == RUN);
        end
    end

    // Next-state and next-value logic; clr beats en=0 beats counting
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_last_nxt  = r_last_count;
        w_win_nxt   = r_win_cnt;
        w_ovf_nxt   = r_overflow;
        w_hit_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_sum       = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(z_in);
        w_win_last  = (window_len != '0) && (r_win_cnt == window_len - WIN_W'(1));

        if (clr) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_last_nxt  = '0;
            w_win_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_count_nxt = '0;
                    w_win_nxt   = '0;
                    if (en) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Partial window is dropped without reporting
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                        w_win_nxt   = '0;
                    end else begin
                        w_win_nxt   = r_win_cnt + WIN_W'(1);
                        w_count_nxt = w_sum;
                        if (z_in && (r_count == CNT_MAX)) begin
                            w_ovf_nxt = 1'b1;
                        end
                        w_hit_nxt = z_in && (threshold != '0) &&
                                    (r_count == threshold - CNT_W'(1));
                        if (w_win_last) begin
                            w_last_nxt  = w_sum;
                            w_done_nxt  = 1'b1;
                            w_count_nxt = '0;
                            w_win_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign count       = r_count;
    assign last_count  = r_last_count;
    assign hit         = r_hit;
    assign window_done = r_window_done;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule
